// File: rtl/tanh_pkg.sv
// Shared constants, ROM image type and the elaboration-time generator for the
// tanh lookup table.
package tanh_pkg;

    localparam int unsigned TANH_DATA_WIDTH = 16;
    localparam int unsigned TANH_ADDR_WIDTH = 9;
    localparam int unsigned TANH_FRAC_BITS  = 8;
    localparam int unsigned TANH_LUT_DEPTH  = 276;
    localparam int unsigned TANH_MAX_ADDR   = 275;

    localparam logic [TANH_DATA_WIDTH-1:0] TANH_ONE     = 16'h0100;
    localparam logic [TANH_DATA_WIDTH-1:0] TANH_NEG_ONE = 16'hFF00;

    // Name of the memory image for flows that preload the ROM from a file.
    localparam string TANH_ROM_FILE = "tanh_lut.mem";

    typedef logic [TANH_LUT_DEPTH-1:0][TANH_DATA_WIDTH-1:0] tanh_rom_image_t;

    // Entry i = round(256 * tanh(x)), x = (3264 + 128 i) / 13056.
    // exp(2x) by a Q32 Taylor series, then tanh = (E - 1) / (E + 1).
    function automatic tanh_rom_image_t tanh_rom_image();
        tanh_rom_image_t img;
        longint          num;
        longint          term;
        longint          e;
        longint          r;
        longint          s;
        s = 64'sd1 <<< 32;
        for (int i = 0; i < TANH_LUT_DEPTH; i++) begin
            num  = longint'(3264 + 128 * i);
            term = s;
            e    = s;
            for (int n = 1; n <= 40; n++) begin
                term = (term * num) / longint'(6528 * n);
                e    = e + term;
            end
            r      = (64'sd512 * (e - s) + (e + s)) / (64'sd2 * (e + s));
            img[i] = TANH_DATA_WIDTH'(r);
        end
        return img;
    endfunction

endpackage

// File: rtl/tanh_lut_rom.sv
// Synchronous-read tanh ROM with read enable; out-of-range addresses read the
// last entry.
module tanh_lut_rom
    import tanh_pkg::*;
#(
    parameter int unsigned DEPTH      = TANH_LUT_DEPTH,
    parameter int unsigned ADDR_WIDTH = TANH_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = TANH_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam tanh_rom_image_t       IMAGE = tanh_rom_image();
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] addr_c;

    assign addr_c = (addr > LAST) ? LAST : addr;

    // Registered read, no reset, so the table maps onto a block RAM.
    always_ff @(posedge clk) begin
        if (re) begin
            data <= IMAGE[addr_c];
        end
    end

endmodule

// File: rtl/tanh_lut_stage.sv
// Two-stage tanh lookup: ROM read, then symmetry/saturation select, with a
// single global advance enable for valid/ready backpressure.
module tanh_lut_stage
    import tanh_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned LUT_DEPTH  = 276
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_use_symmetry,
    input  logic                  in_sat_low,
    input  logic                  in_sat_high,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y
);

    localparam logic [DATA_WIDTH-1:0] SAT_POS = DATA_WIDTH'(1) << FRAC_BITS;
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = -SAT_POS;

    logic                  en;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_x;
    logic                  s1_neg;
    logic                  s1_low;
    logic                  s1_high;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] y_sel;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    tanh_lut_rom #(
        .DEPTH      (LUT_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rom (
        .clk  (clk),
        .re   (en),
        .addr (in_addr),
        .data (rom_q)
    );

    // High saturation wins over low; odd symmetry negates the table value.
    always_comb begin
        y_sel = rom_q;
        if (s1_high) begin
            y_sel = s1_neg ? SAT_NEG : SAT_POS;
        end else if (s1_low) begin
            y_sel = s1_x;
        end else if (s1_neg) begin
            y_sel = -rom_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_neg    <= 1'b0;
            s1_low    <= 1'b0;
            s1_high   <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_x      <= in_x;
            s1_neg    <= in_use_symmetry;
            s1_low    <= in_sat_low;
            s1_high   <= in_sat_high;
            out_valid <= s1_valid;
            out_y     <= y_sel;
        end
    end

endmodule

// File: tb/tb_tanh_lut_stage.sv
// Scoreboard bench for tanh_lut_stage: directed vectors, backpressure, reset
// and a full positive/negative address sweep.
module tb_tanh_lut_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [8:0]  in_addr;
    logic        in_use_symmetry;
    logic        in_sat_low;
    logic        in_sat_high;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;

    typedef struct {
        logic [15:0] y;
        int          cyc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [8:0]  a;
        bit          sym;
        bit          low;
        bit          high;
        logic [15:0] y;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        dir_vec[12];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          pidx = 0;
    logic [3:0]  rdy_pat = 4'b1001;
    bit          prev_stall = 0;
    logic [15:0] held_y;

    tanh_lut_stage #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (9),
        .FRAC_BITS  (8),
        .LUT_DEPTH  (276)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_x            (in_x),
        .in_addr         (in_addr),
        .in_use_symmetry (in_use_symmetry),
        .in_sat_low      (in_sat_low),
        .in_sat_high     (in_sat_high),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_y           (out_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] tanh_ref(input int i);
        real x;
        x = (64.0 + real'(i) * 128.0 / 51.0) / 256.0;
        return 16'($rtoi(256.0 * $tanh(x) + 0.5));
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Downstream ready: always 1, or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            out_ready = 1'b1;
        end else begin
            out_ready = rdy_pat[3 - pidx];
            pidx      = (pidx + 1) % 4;
        end
    end

    // Monitor: looks at the values that the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check_int("stall_valid_hold", int'(out_valid), 1);
                check16("stall_y_hold", out_y, held_y);
            end
            prev_stall = 0;
            if (out_valid && !out_ready) begin
                check_int("stall_in_ready", int'(in_ready), 0);
                prev_stall = 1;
                held_y     = out_y;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_y);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check16("out_y", out_y, e.y);
                    if (e.lat) check_int("latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] x, input logic [8:0] a, input bit sym,
                        input bit low, input bit high, input logic [15:0] y, input bit lat);
        int   waited;
        exp_t e;
        in_x            = x;
        in_addr         = a;
        in_use_symmetry = sym;
        in_sat_low      = low;
        in_sat_high     = high;
        in_valid        = 1'b1;
        waited          = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
        end else begin
            e.y   = y;
            e.cyc = cyc;
            e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int waited;
        dir_vec = '{
            '{16'h0100, 9'd76,  1'b0, 1'b0, 1'b0, 16'h00C2},
            '{16'hFF00, 9'd76,  1'b1, 1'b0, 1'b0, 16'hFF3E},
            '{16'h0020, 9'd0,   1'b0, 1'b1, 1'b0, 16'h0020},
            '{16'hFFE0, 9'd0,   1'b1, 1'b1, 1'b0, 16'hFFE0},
            '{16'h0400, 9'd275, 1'b0, 1'b0, 1'b1, 16'h0100},
            '{16'hFC00, 9'd275, 1'b1, 1'b0, 1'b1, 16'hFF00},
            '{16'h0300, 9'd200, 1'b0, 1'b1, 1'b1, 16'h0100},
            '{16'hFD00, 9'd200, 1'b1, 1'b1, 1'b1, 16'hFF00},
            '{16'h0040, 9'd0,   1'b0, 1'b0, 1'b0, 16'h003F},
            '{16'hFFC0, 9'd0,   1'b1, 1'b0, 1'b0, 16'hFFC1},
            '{16'h02F2, 9'd275, 1'b0, 1'b0, 1'b0, 16'h00FF},
            '{16'hFD0E, 9'd275, 1'b1, 1'b0, 1'b0, 16'hFF01}
        };
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        in_x            = '0;
        in_addr         = '0;
        in_use_symmetry = 1'b0;
        in_sat_low      = 1'b0;
        in_sat_high     = 1'b0;
        out_ready       = 1'b1;
        #3;
        check_int("reset_out_valid", int'(out_valid), 0);
        check16("reset_out_y", out_y, 16'h0000);
        check_int("reset_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (dir_vec[i]) begin
            send(dir_vec[i].x, dir_vec[i].a, dir_vec[i].sym, dir_vec[i].low,
                 dir_vec[i].high, dir_vec[i].y, 1'b1);
        end

        rdy_mode = 1;
        for (int i = 0; i < 4; i++) send(16'h0100, 9'(i), 1'b0, 1'b0, 1'b0, tanh_ref(i), 1'b0);
        for (int i = 0; i < 4; i++) send(16'hFF00, 9'(i), 1'b1, 1'b0, 1'b0, -tanh_ref(i), 1'b0);
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check_int("bp_drained", exp_q.size(), 0);
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Two items in flight, then an asynchronous reset between edges.
        send(16'h0100, 9'd10, 1'b0, 1'b0, 1'b0, tanh_ref(10), 1'b0);
        send(16'h0100, 9'd20, 1'b0, 1'b0, 1'b0, tanh_ref(20), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_int("async_rst_valid", int'(out_valid), 0);
        check16("async_rst_y", out_y, 16'h0000);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0100, 9'd76, 1'b0, 1'b0, 1'b0, 16'h00C2, 1'b1);
        send(16'hFF00, 9'd76, 1'b1, 1'b0, 1'b0, 16'hFF3E, 1'b1);

        for (int i = 0; i < 276; i++) begin
            send(16'h0100, 9'(i), 1'b0, 1'b0, 1'b0, tanh_ref(i), 1'b1);
        end
        for (int i = 0; i < 276; i++) begin
            send(16'hFF00, 9'(i), 1'b1, 1'b0, 1'b0, -tanh_ref(i), 1'b1);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check_int("final_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
